// File: rtl/binary_to_bcd_stream_if.sv
// Valid/ready bundle for the binary-to-BCD converter: a word in, packed BCD digits out.
// DIGITS is derived from WIDTH here so that the interface and the converter always agree.
interface binary_to_bcd_stream_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = int'((64'(WIDTH) * 64'd301029995664 + 64'd999999999999) / 64'd1000000000000)
);
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic                out_neg;
    logic [DIGITS-1:0]   out_lead_zero;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bcd,
        output out_neg,
        output out_lead_zero,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bcd,
        input  out_neg,
        input  out_lead_zero,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/binary_to_bcd_stream.sv
// Handshaked double-dabble binary-to-BCD converter with sign handling and a leading-zero mask.
// STEPS_PER_CYCLE shift-and-add-3 steps are cascaded per clock; results hold until the next conversion.
module binary_to_bcd_stream #(
    parameter int WIDTH           = 8,
    parameter int SIGNED          = 0,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int DIGITS          = int'((64'(WIDTH) * 64'd301029995664 + 64'd999999999999) / 64'd1000000000000)
) (
    input  logic                  clk,
    input  logic                  reset,
    binary_to_bcd_stream_if.slave bus
);
    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [DIGITS-1:0] lz_q, lz_d;

    logic [BW-1:0]     acc_w;
    logic [WIDTH-1:0]  src_w;
    logic [DIGITS-1:0] lz_w;
    logic              in_neg;
    logic [WIDTH-1:0]  in_mag;

    // Out-of-range digit codes map to 0 so the datapath never propagates X.
    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd0;
        end else if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    always_comb begin
        acc_w = acc_q;
        src_w = shift_q;
        for (int unsigned s = 0; s < STEPS_PER_CYCLE; s++) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                acc_w[4*d +: 4] = add3(acc_w[4*d +: 4]);
            end
            acc_w = {acc_w[BW-2:0], src_w[WIDTH-1]};
            src_w = {src_w[WIDTH-2:0], 1'b0};
        end
    end

    // Scan from the top digit down; digit 0 is never blanked.
    always_comb begin
        logic all_zero;
        lz_w     = '0;
        all_zero = 1'b1;
        for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
            all_zero = all_zero && (acc_w[4*(DIGITS-1-i) +: 4] == 4'd0);
            lz_w[DIGITS-1-i] = all_zero;
        end
    end

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign in_neg = (SIGNED != 0) && bus.in_data[WIDTH-1];
    assign in_mag = in_neg ? -bus.in_data : bus.in_data;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        lz_d    = lz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = in_mag;
                    sign_d  = in_neg;
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                shift_d = src_w;
                acc_d   = acc_w;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_w;
                    neg_d   = sign_q;
                    lz_d    = lz_w;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            lz_q    <= LZ_RST;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            lz_q    <= lz_d;
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE) && !reset;
    assign bus.out_valid     = (state_q == S_DONE);
    assign bus.out_bcd       = bcd_q;
    assign bus.out_neg       = neg_q;
    assign bus.out_lead_zero = lz_q;
endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// Directed bench for binary_to_bcd_stream: 8-bit unsigned, 8-bit signed and 16-bit two-steps-per-clock instances.
module tb_binary_to_bcd_stream;
    logic clk;
    logic reset;

    logic [2:0]  iv, ordy;
    logic [15:0] id [3];
    logic [2:0]  ov, ir, on;
    logic [19:0] ob [3];
    logic [4:0]  olz [3];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    binary_to_bcd_stream_if #(.WIDTH(8))  u8_if ();
    binary_to_bcd_stream_if #(.WIDTH(8))  s8_if ();
    binary_to_bcd_stream_if #(.WIDTH(16)) w16_if ();

    binary_to_bcd_stream #(.WIDTH(8), .SIGNED(0), .STEPS_PER_CYCLE(1)) u_u8 (
        .clk(clk), .reset(reset), .bus(u8_if.slave));
    binary_to_bcd_stream #(.WIDTH(8), .SIGNED(1), .STEPS_PER_CYCLE(1)) u_s8 (
        .clk(clk), .reset(reset), .bus(s8_if.slave));
    binary_to_bcd_stream #(.WIDTH(16), .SIGNED(0), .STEPS_PER_CYCLE(2)) u_w16 (
        .clk(clk), .reset(reset), .bus(w16_if.slave));

    assign u8_if.in_data   = id[0][7:0];
    assign s8_if.in_data   = id[1][7:0];
    assign w16_if.in_data  = id[2];
    assign u8_if.in_valid  = iv[0];
    assign s8_if.in_valid  = iv[1];
    assign w16_if.in_valid = iv[2];
    assign u8_if.out_ready  = ordy[0];
    assign s8_if.out_ready  = ordy[1];
    assign w16_if.out_ready = ordy[2];

    assign ov  = {w16_if.out_valid, s8_if.out_valid, u8_if.out_valid};
    assign ir  = {w16_if.in_ready, s8_if.in_ready, u8_if.in_ready};
    assign on  = {w16_if.out_neg, s8_if.out_neg, u8_if.out_neg};
    assign ob[0]  = {8'd0, u8_if.out_bcd};
    assign ob[1]  = {8'd0, s8_if.out_bcd};
    assign ob[2]  = w16_if.out_bcd;
    assign olz[0] = {2'd0, u8_if.out_lead_zero};
    assign olz[1] = {2'd0, s8_if.out_lead_zero};
    assign olz[2] = w16_if.out_lead_zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents val to instance w, waits for the handshake, then counts edges until out_valid.
    task automatic convert(input int w, input logic [15:0] val, output int lat);
        int guard;
        id[w] = val;
        iv[w] = 1'b1;
        guard = 0;
        while (!ir[w] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        iv[w] = 1'b0;
        lat = 0;
        while (!ov[w] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int hs_n, res_n;
        int hs_t [2];
        logic [19:0] res [2];
        logic pre_in, pre_out;
        logic [19:0] pre_bcd;

        iv = '0;
        ordy = '0;
        for (int i = 0; i < 3; i++) id[i] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir[0]), 32'd0);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_bcd", 32'(ob[0]), 32'h000);
        check("rst_neg", 32'(on[0]), 32'd0);
        check("rst_lz", 32'(olz[0]), 32'b110);
        check("rst_lz16", 32'(olz[2]), 32'b11110);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(ir[0]), 32'd1);

        // Unsigned full scale.
        ordy = 3'b111;
        convert(0, 16'd255, lat);
        check("u255_lat", 32'(lat), 32'd8);
        check("u255_bcd", 32'(ob[0]), 32'h255);
        check("u255_lz", 32'(olz[0]), 32'b000);
        check("u255_neg", 32'(on[0]), 32'd0);
        @(posedge clk); #1;
        check("u255_drain_ov", 32'(ov[0]), 32'd0);
        check("u255_drain_ir", 32'(ir[0]), 32'd1);
        check("u255_hold_bcd", 32'(ob[0]), 32'h255);

        // Signed boundaries.
        convert(1, 16'h0080, lat);
        check("s80_lat", 32'(lat), 32'd8);
        check("s80_bcd", 32'(ob[1]), 32'h128);
        check("s80_neg", 32'(on[1]), 32'd1);
        check("s80_lz", 32'(olz[1]), 32'b000);
        convert(1, 16'h00FF, lat);
        check("sFF_bcd", 32'(ob[1]), 32'h001);
        check("sFF_neg", 32'(on[1]), 32'd1);
        check("sFF_lz", 32'(olz[1]), 32'b110);
        convert(1, 16'h0000, lat);
        check("s00_bcd", 32'(ob[1]), 32'h000);
        check("s00_neg", 32'(on[1]), 32'd0);
        check("s00_lz", 32'(olz[1]), 32'b110);
        convert(1, 16'h007F, lat);
        check("s7F_bcd", 32'(ob[1]), 32'h127);
        check("s7F_neg", 32'(on[1]), 32'd0);

        // 16-bit, two steps per clock.
        convert(2, 16'd65535, lat);
        check("w65535_lat", 32'(lat), 32'd8);
        check("w65535_bcd", 32'(ob[2]), 32'h65535);
        check("w65535_lz", 32'(olz[2]), 32'b00000);
        convert(2, 16'd1000, lat);
        check("w1000_bcd", 32'(ob[2]), 32'h01000);
        check("w1000_lz", 32'(olz[2]), 32'b10000);
        convert(2, 16'd0, lat);
        check("w0_bcd", 32'(ob[2]), 32'h00000);
        check("w0_lz", 32'(olz[2]), 32'b11110);

        // Backpressure on the unsigned instance.
        ordy[0] = 1'b0;
        convert(0, 16'd42, lat);
        check("bp_lat", 32'(lat), 32'd8);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_ov", 32'(ov[0]), 32'd1);
            check("bp_bcd", 32'(ob[0]), 32'h042);
            check("bp_ir", 32'(ir[0]), 32'd0);
        end
        check("bp_lz", 32'(olz[0]), 32'b100);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ir", 32'(ir[0]), 32'd1);
        check("bp_release_ov", 32'(ov[0]), 32'd0);
        check("bp_release_bcd", 32'(ob[0]), 32'h042);

        // Back-to-back with in_valid held high.
        id[0] = 16'd7;
        iv[0] = 1'b1;
        hs_n = 0;
        res_n = 0;
        for (int c = 0; c < 60 && res_n < 2; c++) begin
            pre_in  = ir[0] && iv[0];
            pre_out = ov[0] && ordy[0];
            pre_bcd = ob[0];
            @(posedge clk); #1;
            if (pre_in && hs_n < 2) begin
                hs_t[hs_n] = cyc;
                hs_n++;
                if (hs_n == 1) id[0] = 16'd99;
                else iv[0] = 1'b0;
            end
            if (pre_out) begin
                res[res_n] = pre_bcd;
                res_n++;
            end
        end
        iv[0] = 1'b0;
        check("b2b_results", 32'(res_n), 32'd2);
        check("b2b_handshakes", 32'(hs_n), 32'd2);
        if (res_n == 2) begin
            check("b2b_res0", 32'(res[0]), 32'h007);
            check("b2b_res1", 32'(res[1]), 32'h099);
        end
        if (hs_n == 2) check("b2b_period", 32'(hs_t[1] - hs_t[0]), 32'd10);

        // Reset in the middle of a conversion.
        @(posedge clk); #1;
        id[0] = 16'd200;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_ov", 32'(ov[0]), 32'd0);
        check("mid_ir", 32'(ir[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_ov", 32'(ov[0]), 32'd0);
        check("rstmid_bcd", 32'(ob[0]), 32'h000);
        check("rstmid_lz", 32'(olz[0]), 32'b110);
        check("rstmid_ir_in_reset", 32'(ir[0]), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid_ir_after", 32'(ir[0]), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_resume", 32'(ov[0]), 32'd0);
        convert(0, 16'd5, lat);
        check("after_rst_lat", 32'(lat), 32'd8);
        check("after_rst_bcd", 32'(ob[0]), 32'h005);
        check("after_rst_lz", 32'(olz[0]), 32'b110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/binary_to_bcd_stream.md
# binary_to_bcd_stream

Handshaked, parametrised binary-to-BCD converter for display and telemetry paths. It accepts one unsigned or two's-complement word per transaction over a valid/ready input and runs the shift-and-add-3 algorithm for a configurable number of bit steps per clock. It returns packed BCD digits, a sign flag and a leading-zero blanking mask over a valid/ready output. It sits between a producer such as a counter or ADC and a 7-segment digit multiplexer, and converts only on demand.

## Interface
- `WIDTH`, 8: input word width; ≥ 2.
- `SIGNED`, 0: 0 means `in_data` is unsigned; 1 means it is two's complement and the magnitude is converted.
- `STEPS_PER_CYCLE`, 1: double-dabble steps per clock; 1, 2 or 4; must divide `WIDTH`.
- `DIGITS`, ceil(log10(2^WIDTH)): number of output BCD digits; derived, do not override.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  binary word.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block accepts a word.
- `out_bcd`  out  4*DIGITS  BCD result; digit 0 is in bits [3:0].
- `out_neg`  out  1  result is negative; always 0 when SIGNED=0.
- `out_lead_zero`  out  DIGITS  bit d=1 means digit d is a leading zero; bit 0 is always 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CONVERT: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- IDLE→CONVERT on `in_valid && in_ready`. On that edge:
  - Load the magnitude into the shift register. When SIGNED=1 and the MSB is 1, the magnitude is -in_data.
  - Latch the sign into an internal flag.
  - Clear the BCD accumulator.
  - Load the step counter with N = WIDTH/STEPS_PER_CYCLE.
- Each CONVERT cycle performs STEPS_PER_CYCLE cascaded steps. Each step:
  - Add 3 to every accumulator digit ≥ 5.
  - Shift {accumulator, source} left by 1; the source MSB enters accumulator bit 0.
- Decrement the counter each CONVERT cycle. On the edge where the counter goes from 1 to 0:
  - Register the final accumulator into `out_bcd`, the sign flag into `out_neg`, and the computed leading-zero mask into `out_lead_zero`.
  - Go to DONE.
- Most negative input (-2^(WIDTH-1)): the magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits and is converted exactly, with `out_neg`=1.
- Zero input: `out_neg`=0 in both modes. There is no negative zero.
- Leading-zero mask: bit d=1 iff digits d..DIGITS-1 are all 0 and d>0.
- DONE→IDLE on `out_valid && out_ready`.
- `out_bcd`, `out_neg` and `out_lead_zero` are stable from DONE entry until the next DONE entry. They keep their last value through IDLE and CONVERT.
- An `in_valid` pulse that arrives while `in_ready`=0 is not accepted. The producer must hold `in_valid` and `in_data` until the handshake completes.
- Digit values 10–15 never occur internally. The add-3 function returns 0 for them (no X).

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`=0.
  - `out_bcd`=0.
  - `out_neg`=0.
  - `out_lead_zero` = {DIGITS-1 ones, 0}.
  - `in_ready`=0 while `reset` is high, 1 in the first cycle after it is released.
- Reset asserted mid-CONVERT or in DONE abandons the transaction. Outputs return to their reset values on the next edge.
- Latency: input handshake at edge k gives `out_valid`=1 from edge k+N.
- If `out_ready`=1 when DONE is entered, the result handshake happens at edge k+N+1 and `in_ready`=1 from that edge.
- Minimum transaction period: N+2 cycles.
- `out_ready` low holds DONE indefinitely, with outputs unchanged.
- `in_ready` and `out_valid` are pure decodes of the registered state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- WIDTH=8, unsigned, in=255 handshaked at edge k, `out_ready`=1 → `out_valid` at edge k+8, `out_bcd`=0x255, `out_lead_zero`=3'b000, `out_neg`=0.
- WIDTH=8, SIGNED=1, in=8'h80 → `out_bcd`=0x128, `out_neg`=1; in=8'hFF → 0x001, `out_neg`=1, mask 3'b110; in=0 → 0x000, `out_neg`=0, mask 3'b110.
- WIDTH=16, STEPS_PER_CYCLE=2, in=65535 → `out_bcd`=0x65535 at edge k+8; in=1000 → 0x01000, mask 5'b10000.
- Backpressure: result 42 with `out_ready` held low 5 cycles → `out_valid` stays 1, `out_bcd`=0x042 stable, `in_ready`=0 throughout; `out_ready` high → `in_ready`=1 from the next edge.
- Back-to-back: `in_valid` held high with values 7 then 99, `out_ready`=1 → results 0x007 and 0x099 in order, with N+2 cycles between handshakes.
- Reset mid-CONVERT (3 cycles after accepting 200) → next edge: `out_valid`=0, `out_bcd`=0, `in_ready`=1 after release; a new conversion of 5 gives 0x005.
